// File: rtl/bform_pkg.sv
// Shared definitions for the two-channel delay-and-sum beamformer.
// Holds the sample width, delay-line depth, the sample/pointer types and
// the pair-averaging helper used by the output stage.
package bform_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int MAX_DELAY  = 16;
    localparam int DELAY_W    = $clog2(MAX_DELAY);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic        [DELAY_W-1:0]    ptr_t;

    // Sign-extend by one bit, add, drop the LSB: an arithmetic shift right
    // that rounds toward negative infinity and can never overflow.
    function automatic sample_t avg2(input sample_t a, input sample_t b);
        logic [DATA_WIDTH:0] sum;
        sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        return sample_t'(sum[DATA_WIDTH:1]);
    endfunction

endpackage

// File: rtl/delay_line.sv
// Circular sample buffer for one beamformer channel.
// Ports:
//   i_clk     rising-edge clock
//   i_we      write enable (an accepted pair)
//   i_wr_ptr  shared write pointer owned by the top level
//   i_din     sample to store at i_wr_ptr
//   i_offset  read distance behind the write pointer
//   o_dout    combinational read of entry (i_wr_ptr - i_offset) mod depth,
//             returning the contents from before any same-cycle write
module delay_line
    import bform_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_we,
    input  ptr_t    i_wr_ptr,
    input  sample_t i_din,
    input  ptr_t    i_offset,
    output sample_t o_dout
);

    sample_t r_mem [MAX_DELAY];
    ptr_t    w_rd_idx;

    // Depth is a power of two, so the pointer subtraction wraps naturally.
    assign w_rd_idx = i_wr_ptr - i_offset;
    assign o_dout   = r_mem[w_rd_idx];

    // No reset: stale contents are masked by the fill gating in the top level.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/delay_sum_bform.sv
// Two-channel delay-and-sum beamformer.
// Delays one channel by a programmable whole-sample amount and outputs the
// average of the aligned pair through a two-stage pipeline.
// Ports:
//   i_clk, i_reset           clock; synchronous active-low reset
//   i_a_in/i_a_valid         channel A sample and qualifier
//   i_b_in/i_b_valid         channel B sample and qualifier
//   i_delay, i_delay_ch      steering delay and delayed channel (0=B, 1=A)
//   i_delay_load             strobe capturing the steering and restarting fill
//   o_bform_out/o_bform_valid  averaged sample and one-cycle qualifier
//   o_misalign               sticky: one channel valid arrived without the other
module delay_sum_bform
    import bform_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_a_in,
    input  logic                  i_a_valid,
    input  logic [DATA_WIDTH-1:0] i_b_in,
    input  logic                  i_b_valid,
    input  logic [DELAY_W-1:0]    i_delay,
    input  logic                  i_delay_ch,
    input  logic                  i_delay_load,
    output logic [DATA_WIDTH-1:0] o_bform_out,
    output logic                  o_bform_valid,
    output logic                  o_misalign
);

    localparam logic [DELAY_W:0] FILL_MAX = (DELAY_W+1)'(MAX_DELAY);

    ptr_t             r_wr_ptr;
    ptr_t             r_delay;
    logic             r_dsel;
    logic [DELAY_W:0] r_fill_cnt;
    logic             r_s1_valid;
    sample_t          r_s1_a;
    sample_t          r_s1_b;
    sample_t          r_bform_out;
    logic             r_bform_valid;
    logic             r_misalign;

    logic             w_accept;
    logic             w_fill_ok;
    logic             w_bypass;
    sample_t          w_a_line;
    sample_t          w_b_line;
    sample_t          w_a_aligned;
    sample_t          w_b_aligned;
    logic             w_s2_take;

    assign w_accept  = i_a_valid & i_b_valid;
    assign w_fill_ok = r_fill_cnt >= {1'b0, r_delay};
    assign w_bypass  = (r_delay == '0);

    // Only the selected channel goes through its line; zero delay bypasses it.
    assign w_a_aligned = (r_dsel && !w_bypass)  ? w_a_line : sample_t'(i_a_in);
    assign w_b_aligned = (!r_dsel && !w_bypass) ? w_b_line : sample_t'(i_b_in);

    // A load discards whatever sits in stage 1 as well as the same-cycle pair.
    assign w_s2_take = r_s1_valid & ~i_delay_load;

    delay_line u_line_a (
        .i_clk    (i_clk),
        .i_we     (w_accept),
        .i_wr_ptr (r_wr_ptr),
        .i_din    (sample_t'(i_a_in)),
        .i_offset (r_delay),
        .o_dout   (w_a_line)
    );

    delay_line u_line_b (
        .i_clk    (i_clk),
        .i_we     (w_accept),
        .i_wr_ptr (r_wr_ptr),
        .i_din    (sample_t'(i_b_in)),
        .i_offset (r_delay),
        .o_dout   (w_b_line)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_ptr      <= '0;
            r_delay       <= '0;
            r_dsel        <= 1'b0;
            r_fill_cnt    <= '0;
            r_s1_valid    <= 1'b0;
            r_s1_a        <= '0;
            r_s1_b        <= '0;
            r_bform_out   <= '0;
            r_bform_valid <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            if (i_delay_load) begin
                r_delay    <= i_delay;
                r_dsel     <= i_delay_ch;
                // A pair accepted with the load counts as the first of the new fill.
                r_fill_cnt <= {{DELAY_W{1'b0}}, w_accept};
            end else if (w_accept && (r_fill_cnt != FILL_MAX)) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end

            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_s1_a   <= w_a_aligned;
                r_s1_b   <= w_b_aligned;
            end
            r_s1_valid <= w_accept & ~i_delay_load & w_fill_ok;

            r_bform_valid <= w_s2_take;
            if (w_s2_take) begin
                r_bform_out <= avg2(r_s1_a, r_s1_b);
            end

            if (i_a_valid ^ i_b_valid) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign o_bform_out   = r_bform_out;
    assign o_bform_valid = r_bform_valid;
    assign o_misalign    = r_misalign;

endmodule

// File: tb/tb_delay_sum_bform.sv
// Directed self-checking bench for delay_sum_bform.
module tb_delay_sum_bform;

    logic        clk;
    logic        reset;
    logic [15:0] a_in;
    logic        a_valid;
    logic [15:0] b_in;
    logic        b_valid;
    logic [3:0]  delay;
    logic        delay_ch;
    logic        delay_load;
    logic [15:0] bform_out;
    logic        bform_valid;
    logic        misalign;

    int n_total = 0;
    int n_pass  = 0;

    delay_sum_bform dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_a_in        (a_in),
        .i_a_valid     (a_valid),
        .i_b_in        (b_in),
        .i_b_valid     (b_valid),
        .i_delay       (delay),
        .i_delay_ch    (delay_ch),
        .i_delay_load  (delay_load),
        .o_bform_out   (bform_out),
        .o_bform_valid (bform_valid),
        .o_misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic bv, input logic [15:0] a, input logic [15:0] b);
        a_valid = av;
        b_valid = bv;
        a_in    = a;
        b_in    = b;
    endtask

    task automatic load(input logic [3:0] d, input logic ch);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        delay      = d;
        delay_ch   = ch;
        delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
    endtask

    // Delayed channel carries 2k, the other carries k; expected output of
    // pair j is (j + 2(j-3)) >> 1 once the delay line has filled.
    task automatic steer(input logic ch);
        int j;
        int e;
        load(4'd3, ch);
        for (int k = 1; k <= 25; k++) begin
            if (k <= 24) begin
                if (ch) drive(1'b1, 1'b1, 16'(2*k), 16'(k));
                else    drive(1'b1, 1'b1, 16'(k), 16'(2*k));
            end else begin
                drive(1'b0, 1'b0, 16'h0, 16'h0);
            end
            tick();
            j = k - 1;
            chk(ch ? "steer_a_valid" : "steer_b_valid", 16'(bform_valid), 16'(j >= 4));
            if (j >= 4) begin
                e = (3*j - 6) >>> 1;
                chk(ch ? "steer_a_out" : "steer_b_out", bform_out, 16'(e));
            end
        end
    endtask

    logic [15:0] ext_a [5] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF};
    logic [15:0] ext_b [5] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h0000};
    logic [15:0] ext_e [5] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'hFFFF};

    initial begin
        reset      = 1'b0;
        delay      = 4'd0;
        delay_ch   = 1'b0;
        delay_load = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0);

        // Reset held while valid pairs are presented.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'(100 + i), 16'(200 + i));
            tick();
            chk("rst_valid", 16'(bform_valid), 16'h0);
            chk("rst_out", bform_out, 16'h0);
            chk("rst_misalign", 16'(misalign), 16'h0);
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        tick();

        // Bypass: two-edge latency, back-to-back, hold when idle.
        load(4'd0, 1'b0);
        drive(1'b1, 1'b1, 16'd100, 16'd300);
        tick();
        chk("byp_lat_valid", 16'(bform_valid), 16'h0);
        drive(1'b1, 1'b1, 16'd10, 16'd20);
        tick();
        chk("byp_valid0", 16'(bform_valid), 16'h1);
        chk("byp_out0", bform_out, 16'd200);
        drive(1'b1, 1'b1, 16'hFFFC, 16'hFFFA);
        tick();
        chk("byp_valid1", 16'(bform_valid), 16'h1);
        chk("byp_out1", bform_out, 16'd15);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("byp_valid2", 16'(bform_valid), 16'h1);
        chk("byp_out2", bform_out, 16'hFFFB);
        tick();
        chk("byp_idle_valid", 16'(bform_valid), 16'h0);
        chk("byp_hold", bform_out, 16'hFFFB);

        // Steering on each channel, long enough to wrap the pointer.
        steer(1'b0);
        steer(1'b1);

        // Extremes in bypass.
        load(4'd0, 1'b0);
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) drive(1'b1, 1'b1, ext_a[i], ext_b[i]);
            else       drive(1'b0, 1'b0, 16'h0, 16'h0);
            tick();
            if (i > 0) begin
                chk("ext_valid", 16'(bform_valid), 16'h1);
                chk("ext_out", bform_out, ext_e[i-1]);
            end
        end

        // Misalign: lone A sample dropped, flag sticks, pairs still work.
        chk("mis_pre", 16'(misalign), 16'h0);
        drive(1'b1, 1'b0, 16'd999, 16'h0);
        tick();
        chk("mis_set", 16'(misalign), 16'h1);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("mis_no_out", 16'(bform_valid), 16'h0);
        chk("mis_hold", 16'(misalign), 16'h1);
        drive(1'b1, 1'b1, 16'd50, 16'd70);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("mis_pair_valid", 16'(bform_valid), 16'h1);
        chk("mis_pair_out", bform_out, 16'd60);
        chk("mis_still", 16'(misalign), 16'h1);

        // Reload to 5 coincident with a pair while another sits in stage 1.
        drive(1'b1, 1'b1, 16'd7, 16'd7);
        tick();
        for (int k = 1; k <= 9; k++) begin
            int p;
            if (k <= 8) drive(1'b1, 1'b1, 16'(10*k), 16'(10*k));
            else        drive(1'b0, 1'b0, 16'h0, 16'h0);
            if (k == 1) begin
                delay      = 4'd5;
                delay_ch   = 1'b0;
                delay_load = 1'b1;
            end
            tick();
            delay_load = 1'b0;
            p = k - 1;
            chk("rld_valid", 16'(bform_valid), 16'(p >= 6));
            if (p >= 6) chk("rld_out", bform_out, 16'(10*p - 25));
        end

        // Reset mid-stream.
        drive(1'b1, 1'b1, 16'd40, 16'd40);
        tick();
        reset = 1'b0;
        tick();
        chk("mrst_valid", 16'(bform_valid), 16'h0);
        chk("mrst_out", bform_out, 16'h0);
        chk("mrst_misalign", 16'(misalign), 16'h0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 16'd8, 16'd4);
        tick();
        chk("mrst_lat", 16'(bform_valid), 16'h0);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("mrst_valid2", 16'(bform_valid), 16'h1);
        chk("mrst_out2", bform_out, 16'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
